// File: rtl/fir_sample_feeder.sv
// -----------------------------------------------------------------------------
// fir_sample_feeder
//
// Upstream stage of every band FIR. Converts signed fixed-point ADC samples
// into the 10-bit float format {sign[9], exp[8:5] bias 7, mant[4:0] hidden-1;
// all-zero = 0.0}. Converted words are queued in a FIFO and issued one at a
// time to the filter. The next word is issued only after the filter has
// acknowledged the start and then raised its completion level again.
//
// Optional feature macro: FEEDER_TIMEOUT_EN
//   defined   : a 10-bit watchdog counts cycles spent waiting on the filter.
//               Reaching TIMEOUT sets the sticky timeout flag and returns the
//               FSM to IDLE, discarding the in-flight sample.
//   undefined : no watchdog, the FSM waits indefinitely, timeout is 0.
//
// Ports
//   clk_fast   in   1               sole clock, rising edge
//   rst        in   1               asynchronous reset, active low
//   clr        in   1               synchronous clear: flush FIFO, clear
//                                   ovf/timeout, FSM to IDLE (fir_in kept)
//   adc_in     in   IN_W            two's complement sample
//   adc_valid  in   1               one-cycle write strobe for adc_in
//   fir_done   in   1               filter completion level (high = idle)
//   fir_in     out  10              float sample, stable from issue to done
//   fir_en     out  1               one-cycle start pulse to the filter
//   fifo_level out  $clog2(DEPTH+1) entries currently queued
//   busy       out  1               FSM not in IDLE
//   ovf        out  1               sticky: a sample was dropped (FIFO full)
//   timeout    out  1               sticky watchdog flag
// -----------------------------------------------------------------------------
module fir_sample_feeder #(
    parameter int IN_W      = 12,
    parameter int FRAC_BITS = 11,
    parameter int DEPTH     = 8,
    parameter int TIMEOUT   = 1023
) (
    input  logic                       clk_fast,
    input  logic                       rst,
    input  logic                       clr,
    input  logic [IN_W-1:0]            adc_in,
    input  logic                       adc_valid,
    input  logic                       fir_done,
    output logic [9:0]                 fir_in,
    output logic                       fir_en,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       busy,
    output logic                       ovf,
    output logic                       timeout
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_POP      = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_LOW = 3'd3,
        ST_WAIT_HI  = 3'd4
    } state_t;

    // Fixed-point to 10-bit float. The magnitude of the most negative input
    // is representable in IN_W unsigned bits, so no wrap occurs.
    function automatic logic [9:0] to_float(input logic [IN_W-1:0] smp);
        logic [IN_W-1:0] mag;
        logic [4:0]      mant;
        int              p;
        int              e;
        logic [9:0]      res;
        mag = smp[IN_W-1] ? (-smp) : smp;
        p   = 0;
        for (int i = 0; i < IN_W; i++) begin
            p = mag[i] ? i : p;
        end
        // Shifting {mag,00000} right by p leaves the five bits below the
        // leading one in [4:0], zero-padded when fewer than five exist.
        mant = 5'(({mag, 5'b00000}) >> p);
        e    = p - FRAC_BITS + 7;
        if (mag == '0) begin
            res = 10'h000;
        end else if (e > 32'sd15) begin
            res = {smp[IN_W-1], 4'hF, 5'h1F};
        end else if (e < 32'sd1) begin
            res = 10'h000;
        end else begin
            res = {smp[IN_W-1], e[3:0], mant};
        end
        return res;
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic [9:0]        conv_r;
    logic              conv_vld_r;
    logic [9:0]        mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic [9:0]        fir_in_r;
    logic              fir_en_r;
    logic              busy_r;
    logic              ovf_r;
    logic              full_s;
    logic              empty_s;
    logic              rd_s;
    logic              wr_s;
    logic              push_s;
    logic              drop_s;
    logic              abort_s;

    assign full_s  = (level_r == LVL_W'(DEPTH));
    assign empty_s = (level_r == '0);
    // The head is read on the IDLE->POP transition so fir_in is valid in POP.
    assign rd_s    = (state_r == ST_IDLE) && !empty_s && !clr;
    assign wr_s    = conv_vld_r && !clr;
    // A simultaneous read frees the slot, so a full FIFO still accepts.
    assign push_s  = wr_s && (!full_s || rd_s);
    assign drop_s  = wr_s && full_s && !rd_s;

    // Conversion stage: one registered pipeline step ahead of the FIFO.
    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            conv_r     <= 10'h000;
            conv_vld_r <= 1'b0;
        end else begin
            if (adc_valid) begin
                conv_r <= to_float(adc_in);
            end else begin
                conv_r <= conv_r;
            end
            conv_vld_r <= adc_valid && !clr;
        end
    end

    // FIFO storage array; contents are qualified by the level counter.
    always_ff @(posedge clk_fast) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= conv_r;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, rd_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Sample register towards the filter; deliberately untouched by clr.
    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            fir_in_r <= 10'h000;
        end else if (rd_s) begin
            fir_in_r <= mem_r[rd_ptr_r];
        end else begin
            fir_in_r <= fir_in_r;
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            ovf_r <= 1'b0;
        end else if (clr) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Next-state logic; clr overrides every transition.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) state_s = ST_POP;
                else          state_s = ST_IDLE;
            end
            ST_POP:   state_s = ST_ISSUE;
            ST_ISSUE: state_s = ST_WAIT_LOW;
            ST_WAIT_LOW: begin
                if (abort_s)       state_s = ST_IDLE;
                else if (!fir_done) state_s = ST_WAIT_HI;
                else               state_s = ST_WAIT_LOW;
            end
            ST_WAIT_HI: begin
                if (abort_s)       state_s = ST_IDLE;
                else if (fir_done) state_s = ST_IDLE;
                else               state_s = ST_WAIT_HI;
            end
            default: state_s = ST_IDLE;
        endcase
        if (clr) begin
            state_s = ST_IDLE;
        end else begin
            state_s = state_s;
        end
    end

    // State register; fir_en and busy are registered decodes of next state.
    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            fir_en_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            fir_en_r <= (state_s == ST_ISSUE);
            busy_r   <= (state_s != ST_IDLE);
        end
    end

`ifdef FEEDER_TIMEOUT_EN
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

    logic [9:0] wait_cnt_r;
    logic       timeout_r;
    logic       in_wait_s;

    assign in_wait_s = (state_r == ST_WAIT_LOW) || (state_r == ST_WAIT_HI);
    assign abort_s   = in_wait_s && (wait_cnt_r == TMO_LAST);

    // Watchdog: counts every cycle spent in either wait state.
    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= 10'd0;
            timeout_r  <= 1'b0;
        end else if (clr) begin
            wait_cnt_r <= 10'd0;
            timeout_r  <= 1'b0;
        end else if (abort_s) begin
            wait_cnt_r <= 10'd0;
            timeout_r  <= 1'b1;
        end else if (in_wait_s) begin
            wait_cnt_r <= wait_cnt_r + 10'd1;
        end else begin
            wait_cnt_r <= 10'd0;
        end
    end

    assign timeout = timeout_r;
`else
    logic unused_timeout_s;

    assign abort_s          = 1'b0;
    assign timeout          = 1'b0;
    assign unused_timeout_s = (TIMEOUT > 32'sd0);
`endif

    assign fir_in     = fir_in_r;
    assign fir_en     = fir_en_r;
    assign fifo_level = level_r;
    assign busy       = busy_r;
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_fir_sample_feeder.sv
module tb_fir_sample_feeder;

    localparam int IN_W  = 12;
    localparam int DEPTH = 8;
    localparam int TMO   = 20;

    logic        clk_fast;
    logic        rst;
    logic        clr;
    logic [11:0] adc_in;
    logic        adc_valid;
    logic        fir_done;
    logic [9:0]  fir_in;
    logic        fir_en;
    logic [3:0]  fifo_level;
    logic        busy;
    logic        ovf;
    logic        timeout;

    fir_sample_feeder #(
        .IN_W(IN_W), .FRAC_BITS(11), .DEPTH(DEPTH), .TIMEOUT(TMO)
    ) dut (
        .clk_fast(clk_fast), .rst(rst), .clr(clr), .adc_in(adc_in),
        .adc_valid(adc_valid), .fir_done(fir_done), .fir_in(fir_in),
        .fir_en(fir_en), .fifo_level(fifo_level), .busy(busy), .ovf(ovf),
        .timeout(timeout)
    );

    initial clk_fast = 1'b0;
    always #5 clk_fast = ~clk_fast;

    int         n_cmp;
    int         n_fail;
    int         cyc;
    logic [9:0] issued_q[$];
    logic [9:0] exp_q[$];
    bit         fm_auto;
    bit         fm_busy;
    bit         prev_en;
    int         fm_timer;
    int         fm_lat;
    logic [9:0] fm_word;
    int         long_pulse;
    int         double_issue;
    int         in_changed;

    // Reference conversion from the format definition using real arithmetic.
    function automatic logic [9:0] ref_float(input logic [11:0] s);
        int  v, mag, ex, e, mant;
        real x;
        logic sgn;
        v   = (s >= 12'd2048) ? int'(s) - 4096 : int'(s);
        sgn = (v < 0);
        mag = sgn ? -v : v;
        if (mag == 0) return 10'h000;
        x  = real'(mag) / 2048.0;
        ex = 0;
        while (x >= 2.0) begin x = x / 2.0; ex++; end
        while (x < 1.0)  begin x = x * 2.0; ex--; end
        e = ex + 7;
        if (e > 15) return {sgn, 4'hF, 5'h1F};
        if (e < 1) return 10'h000;
        mant = $rtoi((x - 1.0) * 32.0);
        return {sgn, 4'(e), 5'(mant)};
    endfunction

    function automatic logic [11:0] pick_sample();
        logic [11:0] s;
        case ($urandom_range(0, 9))
            0: s = 12'h800;
            1: s = 12'h7FF;
            2: s = 12'd32;
            3: s = 12'd31;
            4: s = 12'hFE0;
            5: s = 12'hFE1;
            6: s = 12'h000;
            default: s = 12'($urandom_range(0, 4095));
        endcase
        return s;
    endfunction

    // One clock: sample outputs at the falling edge and run the filter model
    // (done drops 2 cycles after fir_en, rises fm_lat cycles later).
    task automatic tick();
        @(negedge clk_fast);
        cyc++;
        if (fir_en) begin
            issued_q.push_back(fir_in);
            if (prev_en) long_pulse++;
            if (fm_busy) double_issue++;
            if (fm_auto) begin
                fm_busy  = 1'b1;
                fm_timer = 0;
                fm_word  = fir_in;
            end
        end else if (fm_busy) begin
            fm_timer++;
            if (fir_in !== fm_word) in_changed++;
            if (fm_timer == 2) fir_done = 1'b0;
            if (fm_timer == 2 + fm_lat) begin
                fir_done = 1'b1;
                fm_busy  = 1'b0;
            end
        end
        prev_en = fir_en;
    endtask

    task automatic write_sample(input logic [11:0] s);
        adc_in    = s;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic settle(output bit ok);
        int n;
        n = 0;
        tick();
        tick();
        do begin
            tick();
            n++;
        end while ((busy || fifo_level != 4'd0 || fm_busy) && n < 3000);
        ok = !(busy || fifo_level != 4'd0 || fm_busy);
    endtask

    task automatic clear_stats();
        issued_q.delete();
        exp_q.delete();
        long_pulse   = 0;
        double_issue = 0;
        in_changed   = 0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++;
        if ({fir_in, fir_en, fifo_level, busy, ovf, timeout} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {fir_in, fir_en, fifo_level, busy, ovf, timeout});
        end
        @(negedge clk_fast);
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({fir_en, busy, fifo_level} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %h required 0", {fir_en, busy, fifo_level});
        end
    endtask

    task automatic test_single_sample();
        int c0, n0;
        bit ok;
        clear_stats();
        fm_auto = 1'b1; fm_lat = 3; fir_done = 1'b1;
        write_sample(12'h400);
        c0 = cyc;
        n0 = issued_q.size();
        tick();
        n_cmp++;
        if (fifo_level !== 4'd1) begin
            n_fail++;
            $display("FAIL single_level: got %0d required 1", fifo_level);
        end
        while (issued_q.size() == n0 && cyc - c0 < 50) tick();
        n_cmp++;
        if (cyc - c0 != 3) begin
            n_fail++;
            $display("FAIL single_latency: got %0d required 3", cyc - c0);
        end
        n_cmp++;
        if (issued_q.size() != 1 || issued_q[0] !== 10'h0C0) begin
            n_fail++;
            $display("FAIL single_word: got %0d words, first %h required 0c0",
                     issued_q.size(), (issued_q.size() > 0) ? issued_q[0] : 10'h3FF);
        end
        settle(ok);
        n_cmp++;
        if (!ok || issued_q.size() != 1 || long_pulse != 0) begin
            n_fail++;
            $display("FAIL single_settle: ok %0d issued %0d long %0d required 1/1/0",
                     ok, issued_q.size(), long_pulse);
        end
    endtask

    task automatic test_directed_sequence();
        logic [11:0] smp [4];
        logic [9:0]  wrd [4];
        bit ok;
        smp = '{12'hC00, 12'h7FF, 12'h800, 12'h000};
        wrd = '{10'h2C0, 10'h0DF, 10'h2E0, 10'h000};
        clear_stats();
        fm_lat = 3;
        for (int i = 0; i < 4; i++) write_sample(smp[i]);
        settle(ok);
        n_cmp++;
        if (!ok || issued_q.size() != 4) begin
            n_fail++;
            $display("FAIL seq_count: ok %0d got %0d required 4", ok, issued_q.size());
        end
        for (int i = 0; i < 4 && i < issued_q.size(); i++) begin
            n_cmp++;
            if (issued_q[i] !== wrd[i]) begin
                n_fail++;
                $display("FAIL seq_word[%0d]: got %h required %h", i, issued_q[i], wrd[i]);
            end
        end
    endtask

    task automatic test_random_bursts();
        logic [11:0] s;
        int len;
        bit ok;
        clear_stats();
        for (int b = 0; b < 5; b++) begin
            fm_lat = $urandom_range(1, 6);
            len    = $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++) begin
                s = pick_sample();
                exp_q.push_back(ref_float(s));
                write_sample(s);
            end
            settle(ok);
            n_cmp++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rand_settle[%0d]: busy %0d level %0d required idle", b, busy, fifo_level);
            end
        end
        n_cmp++;
        if (issued_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d required %0d", issued_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < issued_q.size(); i++) begin
            n_cmp++;
            if (issued_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_word[%0d]: got %h required %h", i, issued_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if ({ovf, 8'(long_pulse), 8'(double_issue)} !== 17'd0) begin
            n_fail++;
            $display("FAIL rand_flags: ovf %0d long %0d double %0d required 0",
                     ovf, long_pulse, double_issue);
        end
    endtask

    task automatic test_overflow();
        logic [11:0] s;
        bit ok;
        clear_stats();
        fm_auto = 1'b0;
        fir_done = 1'b0;
        // Filter is busy: one sample goes out, DEPTH are queued, the rest drop.
        for (int i = 0; i < 10; i++) begin
            s = pick_sample();
            if (i <= DEPTH) exp_q.push_back(ref_float(s));
            write_sample(s);
        end
        repeat (3) tick();
        n_cmp++;
        if (fifo_level !== 4'(DEPTH) || ovf !== 1'b1 || issued_q.size() != 1) begin
            n_fail++;
            $display("FAIL ovf_state: level %0d ovf %0d issued %0d required %0d/1/1",
                     fifo_level, ovf, issued_q.size(), DEPTH);
        end
        fm_auto = 1'b1; fm_lat = 2; fir_done = 1'b1;
        settle(ok);
        n_cmp++;
        if (!ok || issued_q.size() != DEPTH + 1 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drain: ok %0d issued %0d ovf %0d required 1/%0d/1",
                     ok, issued_q.size(), ovf, DEPTH + 1);
        end
        for (int i = 0; i < exp_q.size() && i < issued_q.size(); i++) begin
            n_cmp++;
            if (issued_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ovf_word[%0d]: got %h required %h", i, issued_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_clear();
        logic [11:0] s0;
        clear_stats();
        fm_auto = 1'b0;
        fir_done = 1'b0;
        s0 = pick_sample();
        write_sample(s0);
        for (int i = 0; i < 3; i++) write_sample(pick_sample());
        // The write of this last sample lands in the same cycle as clr.
        write_sample(pick_sample());
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        n_cmp++;
        if ({fifo_level, busy, ovf} !== 6'd0) begin
            n_fail++;
            $display("FAIL clr_state: level %0d busy %0d ovf %0d required 0", fifo_level, busy, ovf);
        end
        n_cmp++;
        if (fir_in !== ref_float(s0)) begin
            n_fail++;
            $display("FAIL clr_fir_in_kept: got %h required %h", fir_in, ref_float(s0));
        end
        fm_auto = 1'b1; fm_lat = 2; fir_done = 1'b1;
        repeat (20) tick();
        n_cmp++;
        if (issued_q.size() != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_no_issue: issued %0d busy %0d required 1/0", issued_q.size(), busy);
        end
    endtask

    task automatic test_long_latency();
        logic [11:0] s;
        bit ok;
        clear_stats();
        fm_auto = 1'b1; fm_lat = 40; fir_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s = pick_sample();
            exp_q.push_back(ref_float(s));
            write_sample(s);
            repeat ($urandom_range(0, 3)) tick();
        end
        settle(ok);
        n_cmp++;
        if (!ok || issued_q.size() != 5) begin
            n_fail++;
            $display("FAIL long_count: ok %0d got %0d required 5", ok, issued_q.size());
        end
        for (int i = 0; i < 5 && i < issued_q.size(); i++) begin
            n_cmp++;
            if (issued_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL long_word[%0d]: got %h required %h", i, issued_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (double_issue != 0 || in_changed != 0 || long_pulse != 0) begin
            n_fail++;
            $display("FAIL long_window: double %0d changed %0d long %0d required 0",
                     double_issue, in_changed, long_pulse);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] s;
        int n;
        bit ok;
        clear_stats();
        fm_auto = 1'b1; fm_lat = 40; fir_done = 1'b1;
        for (int i = 0; i < 4; i++) write_sample(pick_sample());
        n = 0;
        while (issued_q.size() == 0 && n < 50) begin tick(); n++; end
        repeat (5) tick();
        n_cmp++;
        if (fifo_level !== 4'd3 || busy !== 1'b1 || fir_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_prereset: level %0d busy %0d done %0d required 3/1/0",
                     fifo_level, busy, fir_done);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({fir_in, fir_en, fifo_level, busy, ovf, timeout} !== 18'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h required 0",
                     {fir_in, fir_en, fifo_level, busy, ovf, timeout});
        end
        fm_busy = 1'b0;
        fir_done = 1'b1;
        @(negedge clk_fast);
        rst = 1'b1;
        repeat (30) tick();
        n_cmp++;
        if (issued_q.size() != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_no_issue: issued %0d busy %0d required 1/0", issued_q.size(), busy);
        end
        fm_lat = 3;
        s = pick_sample();
        write_sample(s);
        settle(ok);
        n_cmp++;
        if (!ok || issued_q.size() != 2 || issued_q[issued_q.size()-1] !== ref_float(s)) begin
            n_fail++;
            $display("FAIL mid_restart: ok %0d issued %0d last %h required 1/2/%h", ok,
                     issued_q.size(), issued_q[issued_q.size()-1], ref_float(s));
        end
    endtask

`ifdef FEEDER_TIMEOUT_EN
    task automatic test_timeout();
        logic [11:0] s1;
        int c0, n;
        clear_stats();
        fm_auto = 1'b0;
        fir_done = 1'b1;
        write_sample(pick_sample());
        s1 = pick_sample();
        write_sample(s1);
        n = 0;
        while (issued_q.size() == 0 && n < 50) begin tick(); n++; end
        c0 = cyc;
        while (timeout !== 1'b1 && cyc - c0 < 200) tick();
        n_cmp++;
        if (cyc - c0 != TMO + 1) begin
            n_fail++;
            $display("FAIL tmo_cycles: got %0d required %0d", cyc - c0, TMO + 1);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_idle: busy %0d required 0", busy);
        end
        n = 0;
        while (issued_q.size() < 2 && n < 50) begin tick(); n++; end
        n_cmp++;
        if (issued_q.size() != 2 || issued_q[issued_q.size()-1] !== ref_float(s1)) begin
            n_fail++;
            $display("FAIL tmo_next: issued %0d last %h required 2/%h",
                     issued_q.size(), issued_q[issued_q.size()-1], ref_float(s1));
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        n_cmp++;
        if ({timeout, ovf, fifo_level} !== 6'd0) begin
            n_fail++;
            $display("FAIL tmo_clr: timeout %0d ovf %0d level %0d required 0", timeout, ovf, fifo_level);
        end
    endtask
`else
    task automatic test_no_timeout();
        logic [11:0] s1;
        bit ok;
        clear_stats();
        fm_auto = 1'b0;
        fir_done = 1'b1;
        write_sample(pick_sample());
        s1 = pick_sample();
        write_sample(s1);
        repeat (3 * TMO + 20) tick();
        n_cmp++;
        if (issued_q.size() != 1 || busy !== 1'b1 || timeout !== 1'b0 || fifo_level !== 4'd1) begin
            n_fail++;
            $display("FAIL notmo_wait: issued %0d busy %0d timeout %0d level %0d required 1/1/0/1",
                     issued_q.size(), busy, timeout, fifo_level);
        end
        fir_done = 1'b0;
        tick();
        fir_done = 1'b1;
        fm_auto = 1'b1; fm_lat = 2;
        settle(ok);
        n_cmp++;
        if (!ok || issued_q.size() != 2 || issued_q[issued_q.size()-1] !== ref_float(s1)) begin
            n_fail++;
            $display("FAIL notmo_resume: ok %0d issued %0d last %h required 1/2/%h", ok,
                     issued_q.size(), issued_q[issued_q.size()-1], ref_float(s1));
        end
    endtask
`endif

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0;
        fm_auto = 1'b1; fm_busy = 1'b0; prev_en = 1'b0;
        fm_timer = 0; fm_lat = 3; fm_word = 10'h000;
        rst = 1'b0; clr = 1'b0; adc_in = 12'h000; adc_valid = 1'b0; fir_done = 1'b1;
        clear_stats();
        test_reset();
        test_single_sample();
        test_directed_sequence();
        test_random_bursts();
        test_overflow();
        test_clear();
        test_long_latency();
        test_reset_mid();
`ifdef FEEDER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
